// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath width, reset PC, canonical NOP and the fetch FSM states.
// The FAULT state exists only when IF_MISALIGN_TRAP_EN is defined.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    SETTLE,
    REQ,
    WAIT,
    DROP
`ifdef IF_MISALIGN_TRAP_EN
    , FAULT
`endif
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if_out_reg.sv
// One-entry output register between fetch and decode.
// Priority: reset > flush > load > drain.
module if_out_reg
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  input  logic            load_misaligned,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misaligned
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_instr      <= NOP_INSTR;
      if_misaligned <= 1'b0;
    end else if (flush) begin
      if_valid      <= 1'b0;
      if_instr      <= NOP_INSTR;
      if_misaligned <= 1'b0;
    end else if (load) begin
      if_valid      <= 1'b1;
      if_pc         <= load_pc;
      if_instr      <= load_instr;
      if_misaligned <= load_misaligned;
    end else if (if_valid && if_ready) begin
      // if_pc is left as-is on drain; it is only meaningful while if_valid.
      if_valid      <= 1'b0;
      if_instr      <= NOP_INSTR;
      if_misaligned <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry output register, redirect flush.
// Optional: IF_MISALIGN_TRAP_EN traps on misaligned PCs instead of masking the low address bits.
module instr_fetch
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_load_addr,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misaligned
);

  fetch_state_e    state;
  logic [XLEN-1:0] req_pc;
  logic            can_load;
  logic            pc_misaligned;
  logic            req_fire;
  logic            rsp_load;
  logic            fault_load;

  // A new entry may be fetched only if it has somewhere to land.
  assign can_load = !if_valid || if_ready;

`ifdef IF_MISALIGN_TRAP_EN
  assign pc_misaligned = |pc_in[1:0];
  assign imem_req_addr = pc_in;
  assign fault_load    = (state == REQ) && can_load && pc_misaligned && !redirect_valid;
`else
  assign pc_misaligned = 1'b0;
  assign imem_req_addr = {pc_in[XLEN-1:2], 2'b00};
  assign fault_load    = 1'b0;
`endif

  assign imem_req_valid = (state == REQ) && can_load && !pc_misaligned;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_advance     = req_fire && !redirect_valid;
  assign rsp_load       = (state == WAIT) && imem_rsp_valid && !redirect_valid;

  if_out_reg u_out_reg (
    .clk             (clk),
    .rst             (rst),
    .flush           (redirect_valid),
    .load            (rsp_load || fault_load),
    .load_pc         (fault_load ? pc_in : req_pc),
    .load_instr      (fault_load ? NOP_INSTR : imem_rsp_data),
    .load_misaligned (fault_load),
    .if_ready        (if_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_misaligned   (if_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SETTLE;
      pc_load      <= 1'b1;
      pc_load_addr <= RESET_PC;
      req_pc       <= RESET_PC;
    end else begin
      pc_load <= redirect_valid;
      if (redirect_valid) pc_load_addr <= redirect_pc;
      if (req_fire)       req_pc       <= pc_in;

      if (redirect_valid) begin
        // An accepted-but-unanswered request must have its response swallowed.
        case (state)
          REQ:     state <= req_fire       ? DROP   : SETTLE;
          WAIT:    state <= imem_rsp_valid ? SETTLE : DROP;
          DROP:    state <= imem_rsp_valid ? SETTLE : DROP;
          default: state <= SETTLE;
        endcase
      end else begin
        case (state)
          SETTLE: state <= REQ;
          REQ: begin
            if (req_fire) state <= WAIT;
`ifdef IF_MISALIGN_TRAP_EN
            else if (fault_load) state <= FAULT;
`endif
          end
          WAIT:    if (imem_rsp_valid) state <= REQ;
          DROP:    if (imem_rsp_valid) state <= REQ;
`ifdef IF_MISALIGN_TRAP_EN
          FAULT:   state <= FAULT;
`endif
          default: state <= SETTLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC and a latency-configurable instruction memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misaligned;

  int errors = 0;
  int checks = 0;

  int          mem_lat;
  logic        mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .pc_load        (pc_load),
    .pc_load_addr   (pc_load_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misaligned  (if_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h00A0_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      default:       mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Program counter model.
  initial pc_in = 32'hFFFF_FFF0;
  always @(posedge clk) begin
    if (pc_load)         pc_in <= pc_load_addr;
    else if (pc_advance) pc_in <= pc_in + 32'd4;
  end

  // Instruction memory: responds mem_lat cycles after accept.
  always @(posedge clk) begin
    if (rst) begin
      mem_pending <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_pending <= 1'b1;
      mem_cnt     <= mem_lat;
      mem_addr    <= imem_req_addr;
    end else if (mem_pending) begin
      if (mem_cnt == 1) mem_pending <= 1'b0;
      mem_cnt <= mem_cnt - 1;
    end
  end
  assign imem_rsp_valid = mem_pending && (mem_cnt == 1);
  assign imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 32'hxxxx_xxxx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 1;
    @(negedge clk);
    step();

    check("rst_pc_load",      pc_load,        1);
    check("rst_pc_load_addr", pc_load_addr,   32'h0);
    check("rst_if_valid",     if_valid,       0);
    check("rst_if_pc",        if_pc,          32'h0);
    check("rst_if_instr",     if_instr,       32'h0000_0013);
    check("rst_if_mis",       if_misaligned,  0);
    check("rst_req_valid",    imem_req_valid, 0);

    // Cycle 0: SETTLE with pc_load high.
    rst = 1'b0;
    #1;
    check("c0_pc_load",   pc_load,        1);
    check("c0_req_valid", imem_req_valid, 0);

    step();  // cycle 1: first request
    check("c1_req_valid", imem_req_valid, 1);
    check("c1_req_addr",  imem_req_addr,  32'h0);
    check("c1_advance",   pc_advance,     1);
    check("c1_pc_load",   pc_load,        0);

    step();  // cycle 2: response cycle
    check("c2_advance",   pc_advance,     0);
    check("c2_req_valid", imem_req_valid, 0);
    check("c2_if_valid",  if_valid,       0);

    step();  // cycle 3: first instruction presented, second request
    check("c3_if_valid",  if_valid,       1);
    check("c3_if_pc",     if_pc,          32'h0);
    check("c3_if_instr",  if_instr,       32'h00A0_0093);
    check("c3_req_valid", imem_req_valid, 1);
    check("c3_req_addr",  imem_req_addr,  32'h4);
    check("c3_advance",   pc_advance,     1);

    step();
    check("c4_if_valid", if_valid, 0);

    step();
    check("c5_if_valid", if_valid, 1);
    check("c5_if_pc",    if_pc,    32'h4);
    check("c5_if_instr", if_instr, 32'h0010_0113);

    // Decode stalls: output held, no new request.
    if_ready = 1'b0;
    #1;
    check("stall_req_valid", imem_req_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d_if_valid", i), if_valid,       1);
      check($sformatf("stall%0d_if_pc", i),    if_pc,          32'h4);
      check($sformatf("stall%0d_if_instr", i), if_instr,       32'h0010_0113);
      check($sformatf("stall%0d_req", i),      imem_req_valid, 0);
      check($sformatf("stall%0d_adv", i),      pc_advance,     0);
    end
    if_ready = 1'b1;
    #1;
    check("unstall_req_valid", imem_req_valid, 1);
    check("unstall_req_addr",  imem_req_addr,  32'h8);
    check("unstall_advance",   pc_advance,     1);

    step();
    check("pc8_rsp_if_valid", if_valid, 0);
    step();
    check("pc8_if_pc",    if_pc,    32'h8);
    check("pc8_if_instr", if_instr, 32'hC0DE_0008);

    // Memory backpressure for 3 cycles.
    imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check($sformatf("bp%0d_req_valid", i), imem_req_valid, 1);
      check($sformatf("bp%0d_req_addr", i),  imem_req_addr,  32'hC);
      check($sformatf("bp%0d_advance", i),   pc_advance,     0);
    end
    imem_req_ready = 1'b1;
    #1;
    check("bp_accept_advance", pc_advance, 1);

    // Redirect while in WAIT (response arriving this cycle is discarded).
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("rdw_advance", pc_advance, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rdw_pc_load",      pc_load,        1);
    check("rdw_pc_load_addr", pc_load_addr,   32'h100);
    check("rdw_if_valid",     if_valid,       0);
    check("rdw_req_valid",    imem_req_valid, 0);
    step();
    check("rdw_new_req_valid", imem_req_valid, 1);
    check("rdw_new_req_addr",  imem_req_addr,  32'h100);
    check("rdw_new_pc_load",   pc_load,        0);
    check("rdw_stale_dropped", if_valid,       0);

    // Redirect coinciding with a request handshake.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("rdh_req_valid", imem_req_valid, 1);
    check("rdh_advance",   pc_advance,     0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("rdh_pc_load",      pc_load,        1);
    check("rdh_pc_load_addr", pc_load_addr,   32'h200);
    check("rdh_req_valid2",   imem_req_valid, 0);
    check("rdh_if_valid",     if_valid,       0);
    step();
    check("rdh_new_req_valid", imem_req_valid, 1);
    check("rdh_new_req_addr",  imem_req_addr,  32'h200);
    check("rdh_dropped",       if_valid,       0);
    step();
    check("rdh_rsp_if_valid", if_valid, 0);
    step();
    check("rdh_if_valid_out", if_valid, 1);
    check("rdh_if_pc",        if_pc,    32'h200);
    check("rdh_if_instr",     if_instr, 32'hC0DE_0200);

    // Redirect in WAIT before a 2-cycle response: goes through DROP.
    mem_lat = 2;
    check("d2_req_addr", imem_req_addr, 32'h204);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    #1;
    check("d2_pc_load",      pc_load,        1);
    check("d2_pc_load_addr", pc_load_addr,   32'h300);
    check("d2_if_valid",     if_valid,       0);
    check("d2_req_valid",    imem_req_valid, 0);
    step();
    check("d2_new_req_valid", imem_req_valid, 1);
    check("d2_new_req_addr",  imem_req_addr,  32'h300);
    check("d2_dropped",       if_valid,       0);
    mem_lat = 1;
    step();
    step();
    check("d2_if_valid_out", if_valid, 1);
    check("d2_if_pc",        if_pc,    32'h300);
    check("d2_if_instr",     if_instr, 32'hC0DE_0300);

    // Redirect to a misaligned PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    #1;
    check("mis_pc_load_addr", pc_load_addr, 32'h102);
    step();
`ifdef IF_MISALIGN_TRAP_EN
    if_ready = 1'b0;
    #1;
    check("mis_req_valid", imem_req_valid, 0);
    check("mis_advance",   pc_advance,     0);
    step();
    check("mis_if_valid",  if_valid,       1);
    check("mis_if_mis",    if_misaligned,  1);
    check("mis_if_pc",     if_pc,          32'h102);
    check("mis_if_instr",  if_instr,       32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fault%0d_req_valid", i), imem_req_valid, 0);
      check($sformatf("fault%0d_if_mis", i),    if_misaligned,  1);
    end
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    #1;
    check("fault_exit_pc_load", pc_load,       1);
    check("fault_exit_addr",    pc_load_addr,  32'h400);
    check("fault_exit_valid",   if_valid,      0);
    check("fault_exit_mis",     if_misaligned, 0);
    step();
    check("fault_exit_req_valid", imem_req_valid, 1);
    check("fault_exit_req_addr",  imem_req_addr,  32'h400);
`else
    check("mis_req_valid", imem_req_valid, 1);
    check("mis_req_addr",  imem_req_addr,  32'h100);
    check("mis_advance",   pc_advance,     1);
    step();
    step();
    check("mis_if_valid", if_valid,      1);
    check("mis_if_pc",    if_pc,         32'h102);
    check("mis_if_instr", if_instr,      32'hC0DE_0100);
    check("mis_if_mis",   if_misaligned, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch stage; sits directly downstream of the program counter.
- Takes the current PC and issues one word read to instruction memory over a valid/ready request channel.
- Captures the returned instruction into a one-entry output register, presented to decode with a valid/ready handshake.
- Drives PC advance/load controls and handles branch/jump redirects by discarding in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC driven on pc_load_addr during the reset-exit load.
- NOP_INSTR, 32'h0000_0013, value held on if_instr when no valid instruction is present.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  32  current PC from program counter.
- pc_advance  output  1  combinational; PC increments by 4 at this edge.
- pc_load  output  1  registered; PC loads pc_load_addr at this edge.
- pc_load_addr  output  32  registered redirect target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  word address (pc_in).
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response valid; at least 1 cycle after accept; no backpressure.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  flush pulse from execute.
- redirect_pc  input  32  new fetch target.
- if_valid  output  1  instruction valid to decode.
- if_ready  input  1  decode accepts.
- if_pc  output  32  PC of presented instruction.
- if_instr  output  32  presented instruction.
- if_misaligned  output  1  instruction-address-misaligned flag (macro-dependent).

## Operation
- States: SETTLE, REQ, WAIT, DROP, FAULT. At most one request is outstanding at any time.
- Reset state is SETTLE. Reset values:
  - pc_load=1, pc_load_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR, if_misaligned=0.
  - imem_req_valid=0.
- SETTLE:
  - No request is issued.
  - pc_load deasserts.
  - Next state is REQ.
- REQ:
  - imem_req_valid=1 only when the output register is empty or is being drained this cycle (if_valid&&if_ready).
  - On handshake: pc_advance=1, req_pc<=pc_in, go to WAIT.
- WAIT:
  - On imem_rsp_valid, the output register loads if_valid=1, if_pc=req_pc, if_instr=imem_rsp_data.
  - Next state is REQ.
- Output register clears (if_valid=0, if_instr=NOP_INSTR) on if_valid&&if_ready unless it is reloaded in the same cycle.
- Redirect has the highest priority and applies in any state. In the redirect cycle:
  - pc_advance is forced to 0.
  - Next cycle: pc_load=1, pc_load_addr=redirect_pc, output register cleared.
  - REQ with handshake this cycle goes to DROP; REQ without handshake goes to SETTLE.
  - WAIT with imem_rsp_valid this cycle goes to SETTLE (response discarded); otherwise WAIT goes to DROP.
  - DROP stays DROP; SETTLE and FAULT go to SETTLE.
- DROP: the next imem_rsp_valid is discarded, then go to REQ. No request is issued while in DROP.
- Back-to-back redirects: the last one wins; pc_load re-asserts with the newest target.

## Timing
- Reset released at cycle 0:
  - pc_load is high in cycle 0.
  - First request in cycle 1.
- Fetch latency = memory latency + 1 cycle (registered output).
- Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- Redirect at cycle t:
  - pc_load at t+1.
  - Earliest new request at t+2 with pc_in == redirect_pc.
- if_valid, if_pc and if_instr are stable while if_valid&&!if_ready.

## Configuration
- IF_MISALIGN_TRAP_EN defined:
  - In REQ, if pc_in[1:0]!=0 and the output register can load, no request is issued and pc_advance stays 0.
  - The output register loads if_valid=1, if_misaligned=1, if_pc=pc_in, if_instr=NOP_INSTR, and the state goes to FAULT.
  - FAULT issues nothing until a redirect arrives.
- IF_MISALIGN_TRAP_EN undefined:
  - imem_req_addr[1:0] is forced to 0.
  - if_misaligned is tied to 0.
  - The FAULT state is absent.

## Structure
- Shared package rv_core_pkg holds:
  - the fetch state enum;
  - NOP_INSTR (32'h0000_0013);
  - the XLEN=32 constant.
- One sub-module, if_out_reg: the one-entry output register with load/drain/clear controls and valid/ready semantics.
- The FSM and the redirect logic live in instr_fetch.

## Test plan
- Reset, imem_rsp 1 cycle after accept, if_ready=1, memory returns 32'h00A00093 for PC 0 and 32'h00100113 for PC 4 → if_pc 0 then 4 with those words; pc_advance pulses once per fetch.
- Hold if_ready=0 for 5 cycles after the first instruction → if_valid/if_pc/if_instr unchanged; no second request until if_ready=1.
- imem_req_ready low for 3 cycles → imem_req_valid held with constant address; pc_advance=0 until accept.
- redirect_valid with redirect_pc=32'h0000_0100 while in WAIT → next cycle pc_load=1, pc_load_addr=32'h100, if_valid=0; the stale response is discarded; the next request address is 32'h100.
- Redirect in the same cycle as a request handshake → pc_advance=0; exactly one response dropped; the redirect target is fetched next.
- IF_MISALIGN_TRAP_EN, pc_in=32'h0000_0102 → no imem request; if_valid=1, if_misaligned=1, if_pc=32'h102, if_instr=32'h00000013; idle until redirect.
